fifo_stream_reader: RTL

- Downstream drain stage for FIFO_simple_DP_RAM: issues `read` pulses and absorbs the RAM read latency.
- Presents FIFO contents as a valid/ready stream to the consumer, full throughput (1 word/clk) when the consumer is always ready.
- Sized so no word read from the FIFO is ever dropped under consumer backpressure.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_stream_reader_if.sv | 48 ++++
 rtl/skid_buffer.sv | 50 +++++
 rtl/fifo_stream_reader.sv | 65 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO drain stage.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

`ifdef PIPELINE
  localparam int READ_LATENCY_DEF = 3;
`else
  localparam int READ_LATENCY_DEF = 1;
`endif

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of FIFO-side and consumer-side signals of the drain stage.
//
// Handshake: a word moves on the consumer side at a rising edge where
// out_valid and out_ready are both 1. out_valid and out_data depend only
// on registered state; once out_valid is 1 it stays 1 with stable out_data
// until that word is accepted. On the FIFO side, fifo_read is a one-clock
// read request honoured at every edge where it is 1; fifo_read_data carries
// the requested word READ_LATENCY clocks later.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) ();

  localparam int OCC_W = clog2(READ_LATENCY + 2);

  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_empty;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [OCC_W-1:0]      occupancy;

  // Drain-stage side.
  modport master (
    output fifo_read,
    input  fifo_read_data,
    input  fifo_empty,
    output out_valid,
    output out_data,
    input  out_ready,
    output occupancy
  );

  // Environment side (FIFO plus consumer).
  modport slave (
    input  fifo_read,
    output fifo_read_data,
    output fifo_empty,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  occupancy
  );

endinterface

// File: rtl/skid_buffer.sv
// Circular buffer that absorbs words already requested from the FIFO.
// DEPTH need not be a power of two; pointers wrap explicitly.
module skid_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture,
  input  logic [DATA_WIDTH-1:0]       cap_data,
  input  logic                        pop,
  output logic                        valid,
  output logic [DATA_WIDTH-1:0]       data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Write on capture, advance read side on pop, keep the fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= cap_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CNT_W'(capture) - CNT_W'(pop);
    end
  end

  assign valid = (count != '0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain stage: issues FIFO reads, tracks reads still in the RAM pipeline
// and lands returning words in a skid buffer sized so none are dropped.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master bus
);

  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int CNT_W     = clog2(BUF_DEPTH + 1);

  logic [READ_LATENCY-1:0] rd_pipe;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W:0]          demand;
  logic                    read;
  logic                    pop;
  logic                    capture;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   data;

  // Count requests issued but whose data has not yet been captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
  end

  // A slot freed by this cycle's pop can be claimed by a read this cycle.
  assign pop    = valid & bus.out_ready;
  assign demand = {1'b0, count} + {1'b0, inflight} - (CNT_W + 1)'(pop);
  assign read   = !reset && !bus.fifo_empty && (demand < (CNT_W + 1)'(BUF_DEPTH));

  // Shift a marker alongside each read so capture lines up with RAM data.
  always_ff @(posedge clk) begin
    if (reset) rd_pipe <= '0;
    else       rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(read);
  end

  assign capture = rd_pipe[READ_LATENCY-1];

  skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .cap_data (bus.fifo_read_data),
    .pop      (pop),
    .valid    (valid),
    .data     (data),
    .count    (count)
  );

  assign bus.fifo_read = read;
  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.occupancy = count;

endmodule
